multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter EN_ADDI, default 1, SHALL mean ADDI (op 001000) is decoded; when 0, ADDI is illegal.
REQ-003 Parameter EN_JUMP, default 1, SHALL mean J (op 000010) is decoded; when 0, J is illegal.
REQ-004 Parameter EN_BNE, default 0, SHALL mean BNE (op 000101) is decoded; when 0, BNE is illegal.
REQ-005 Parameter TRAP_ILLEGAL, default 1, SHALL mean an illegal opcode enters TRAP; when 0, the illegal opcode is skipped.
REQ-006 Parameter CNT_W, default 16, SHALL set the width of retire_cnt.
REQ-007 Ports SHALL be as follows (name direction width meaning):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- op  in  6  opcode from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcwrite, branch, branch_ne  out  1 each  datapath controls.
- alusrcb, pcsrc, aluop  out  2 each  datapath selects.
- illegal  out  1  illegal opcode indication.
- state  out  4  current state encoding.
- retire_cnt  out  CNT_W  retired-instruction count.

Function
REQ-008 The block SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12; codes 13-15 SHALL go to FETCH.
REQ-009 Outputs SHALL depend on state only, except that gated terms include mem_ready; any output not listed for a state SHALL be 0.
REQ-010 FETCH SHALL drive alusrcb=01 with irwrite=pcwrite=mem_ready, and SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-011 DECODE SHALL drive alusrcb=11, then branch on op:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 000101 with EN_BNE -> BRANCH
- ADDI with EN_ADDI -> ADDIEX
- J with EN_JUMP -> JUMP
- anything else -> TRAP if TRAP_ILLEGAL, otherwise FETCH.
REQ-012 MEMADR SHALL drive alusrca=1 and alusrcb=10, then go to MEMRD for LW or MEMWR for SW.
REQ-013 MEMRD SHALL drive iord=1 and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-014 MEMWB SHALL drive memtoreg=1 and regwrite=1, then go to FETCH.
REQ-015 MEMWR SHALL drive iord=1 and memwrite=1 and SHALL hold until mem_ready=1, then go to FETCH.
REQ-016 EXEC SHALL drive alusrca=1 and aluop=10, then go to ALUWB.
REQ-017 ALUWB SHALL drive regdst=1 and regwrite=1, then go to FETCH.
REQ-018 BRANCH SHALL drive alusrca=1, aluop=01, pcsrc=01 and branch=1, with branch_ne=1 only when the latched opcode was BNE, then go to FETCH.
REQ-019 The opcode SHALL be latched in DECODE and used in MEMADR and BRANCH.
REQ-020 ADDIEX SHALL drive alusrca=1 and alusrcb=10, then go to ADDIWB.
REQ-021 ADDIWB SHALL drive regwrite=1, then go to FETCH.
REQ-022 JUMP SHALL drive pcsrc=10 and pcwrite=1, then go to FETCH.
REQ-023 TRAP SHALL drive all controls to 0 and illegal=1, and SHALL be absorbing until reset.
REQ-024 With TRAP_ILLEGAL=0, illegal SHALL pulse high for exactly the DECODE cycle of the illegal opcode.
REQ-025 retire_cnt SHALL increment by 1 on every exit from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP into FETCH.
REQ-026 retire_cnt SHALL wrap modulo 2^CNT_W, SHALL not count skipped illegal opcodes, and SHALL not count TRAP.
REQ-027 mem_ready SHALL be ignored in every state except FETCH, MEMRD and MEMWR.
REQ-028 There SHALL be no latency between a state change and its outputs, since outputs are a registered-state decode.

Reset
REQ-029 Assertion of reset_n=0 SHALL immediately force state=FETCH, retire_cnt=0 and illegal=0, including mid-instruction and in TRAP.
REQ-030 While reset is asserted, the FETCH control values SHALL appear with pcwrite=irwrite=0.
REQ-031 On the first clk edge after deassertion with mem_ready=1, the block SHALL leave FETCH.
REQ-032 No memwrite or regwrite pulse SHALL be produced by a reset that interrupts MEMWR, MEMWB or ALUWB.

Verification
REQ-033 R-type, op=000000, mem_ready=1 -> the bench SHALL see states 0,1,6,7,0 and regwrite=1 with regdst=1 only in state 7, and retire_cnt 0->1.
REQ-034 LW, op=100011, with mem_ready low for 3 cycles in MEMRD -> the bench SHALL see 0,1,2,3,3,3,3,4,0, iord=1 for 4 cycles, and a single regwrite with memtoreg=1.
REQ-035 BNE, op=000101, with EN_BNE=1 -> BRANCH SHALL assert branch=1 and branch_ne=1; with EN_BNE=0 and TRAP_ILLEGAL=1 -> state SHALL be 12 and illegal SHALL stick high.
REQ-036 Opcode 111111 with TRAP_ILLEGAL=0 -> illegal SHALL be high for 1 cycle, the state SHALL return to FETCH, and retire_cnt SHALL be unchanged.
REQ-037 With CNT_W=2, 5 ADDI instructions -> retire_cnt SHALL read 1,2,3,0,1.
REQ-038 reset_n pulsed low during MEMWR -> state SHALL be 0 asynchronously, memwrite SHALL be 0 at once, and retire_cnt SHALL be 0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// multicycle_controller: Moore control FSM for a multicycle MIPS-style datapath.
// Revision 1.0
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int EN_ADDI      = 1,
  parameter int EN_JUMP      = 1,
  parameter int EN_BNE       = 0,
  parameter int TRAP_ILLEGAL = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  state_t     dec_target;
  logic       dec_legal;
  logic [5:0] op_q;
  logic       retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // The opcode is only valid during DECODE; later states use this copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 6'd0;
    end else if (cur_state == S_DECODE) begin
      op_q <= op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  always_comb begin
    dec_target = S_FETCH;
    dec_legal  = 1'b1;
    case (op)
      OP_RTYPE:     dec_target = S_EXEC;
      OP_LW, OP_SW: dec_target = S_MEMADR;
      OP_BEQ:       dec_target = S_BRANCH;
      OP_BNE: begin
        if (EN_BNE != 0) dec_target = S_BRANCH;
        else             dec_legal  = 1'b0;
      end
      OP_ADDI: begin
        if (EN_ADDI != 0) dec_target = S_ADDIEX;
        else              dec_legal  = 1'b0;
      end
      OP_J: begin
        if (EN_JUMP != 0) dec_target = S_JUMP;
        else              dec_legal  = 1'b0;
      end
      default:      dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_target = (TRAP_ILLEGAL != 0) ? S_TRAP : S_FETCH;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        // Gated by reset_n so no PC/IR write strobe leaks out while in reset.
        irwrite = mem_ready & reset_n;
        pcwrite = mem_ready & reset_n;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        illegal   = ~dec_legal & (TRAP_ILLEGAL == 0);
        nxt_state = dec_target;
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg  = 1'b1;
        regwrite  = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst    = 1'b1;
        regwrite  = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        branch_ne = (op_q == OP_BNE);
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite   = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        nxt_state = S_TRAP;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_multicycle_controller: scoreboard bench over two parameterisations.
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;

  // Instance A: default parameters.
  logic        a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite;
  logic        a_alusrca, a_pcwrite, a_branch, a_branch_ne, a_illegal;
  logic [1:0]  a_alusrcb, a_pcsrc, a_aluop;
  logic [3:0]  a_state;
  logic [15:0] a_cnt;

  // Instance B: BNE enabled, illegal opcodes skipped, 2-bit counter.
  logic        b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite;
  logic        b_alusrca, b_pcwrite, b_branch, b_branch_ne, b_illegal;
  logic [1:0]  b_alusrcb, b_pcsrc, b_aluop;
  logic [3:0]  b_state;
  logic [1:0]  b_cnt;

  multicycle_controller u_a (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .pcwrite(a_pcwrite), .branch(a_branch), .branch_ne(a_branch_ne),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .aluop(a_aluop), .illegal(a_illegal),
    .state(a_state), .retire_cnt(a_cnt)
  );

  multicycle_controller #(.EN_BNE(1), .TRAP_ILLEGAL(0), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .pcwrite(b_pcwrite), .branch(b_branch), .branch_ne(b_branch_ne),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .aluop(b_aluop), .illegal(b_illegal),
    .state(b_state), .retire_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sa;
    logic [16:0] ca;
    logic [15:0] na;
    logic [3:0]  sb;
    logic [16:0] cb;
    logic [1:0]  nb;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   stepn    = 0;

  wire [16:0] a_ctl = {a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite,
                       a_alusrca, a_pcwrite, a_branch, a_branch_ne, a_alusrcb, a_pcsrc,
                       a_aluop, a_illegal};
  wire [16:0] b_ctl = {b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
                       b_alusrca, b_pcwrite, b_branch, b_branch_ne, b_alusrcb, b_pcsrc,
                       b_aluop, b_illegal};

  // Expected control word per state, written straight from the state table.
  function automatic logic [16:0] exp_ctl(input int st, input logic mr, input logic bne,
                                          input logic ill);
    logic iord_e, mw_e, irw_e, rd_e, m2r_e, rw_e, asa_e, pcw_e, br_e, bne_e, ill_e;
    logic [1:0] asb_e, pcs_e, aop_e;
    {iord_e, mw_e, irw_e, rd_e, m2r_e, rw_e, asa_e, pcw_e, br_e, bne_e, ill_e} = '0;
    asb_e = 2'b00; pcs_e = 2'b00; aop_e = 2'b00;
    case (st)
      0:  begin asb_e = 2'b01; irw_e = mr; pcw_e = mr; end
      1:  begin asb_e = 2'b11; ill_e = ill; end
      2:  begin asa_e = 1'b1; asb_e = 2'b10; end
      3:  iord_e = 1'b1;
      4:  begin m2r_e = 1'b1; rw_e = 1'b1; end
      5:  begin iord_e = 1'b1; mw_e = 1'b1; end
      6:  begin asa_e = 1'b1; aop_e = 2'b10; end
      7:  begin rd_e = 1'b1; rw_e = 1'b1; end
      8:  begin asa_e = 1'b1; aop_e = 2'b01; pcs_e = 2'b01; br_e = 1'b1; bne_e = bne; end
      9:  begin asa_e = 1'b1; asb_e = 2'b10; end
      10: rw_e = 1'b1;
      11: begin pcs_e = 2'b10; pcw_e = 1'b1; end
      12: ill_e = 1'b1;
      default: ;
    endcase
    return {iord_e, mw_e, irw_e, rd_e, m2r_e, rw_e, asa_e, pcw_e, br_e, bne_e,
            asb_e, pcs_e, aop_e, ill_e};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", name, stepn, obs, expv);
    end
  endtask

  task automatic compare_top();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("state_a", {28'd0, a_state}, {28'd0, e.sa});
    chk("ctl_a",   {15'd0, a_ctl},   {15'd0, e.ca});
    chk("cnt_a",   {16'd0, a_cnt},   {16'd0, e.na});
    chk("state_b", {28'd0, b_state}, {28'd0, e.sb});
    chk("ctl_b",   {15'd0, b_ctl},   {15'd0, e.cb});
    chk("cnt_b",   {30'd0, b_cnt},   {30'd0, e.nb});
  endtask

  // Called at posedge+1: drive inputs, record expectation, check at negedge.
  task automatic step(input logic [5:0] o, input logic m, input int sa, input int sb,
                      input int na, input int nb, input logic bneb, input logic illb);
    exp_t e;
    stepn++;
    op = o;
    mem_ready = m;
    e.sa = 4'(sa); e.ca = exp_ctl(sa, m, 1'b0, 1'b0); e.na = 16'(na);
    e.sb = 4'(sb); e.cb = exp_ctl(sb, m, bneb, illb); e.nb = 2'(nb);
    sb_q.push_back(e);
    @(negedge clk);
    compare_top();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle and checks the outputs collapse immediately.
  task automatic async_reset_check();
    exp_t e;
    stepn++;
    #2;
    reset_n = 1'b0;
    #1;
    e.sa = 4'd0; e.ca = exp_ctl(0, 1'b0, 1'b0, 1'b0); e.na = 16'd0;
    e.sb = 4'd0; e.cb = exp_ctl(0, 1'b0, 1'b0, 1'b0); e.nb = 2'd0;
    sb_q.push_back(e);
    compare_top();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = 6'd0;
    mem_ready = 1'b1;
    #2;
    async_reset_check();

    // R-type
    step(6'h00, 1, 0, 0, 0, 0, 0, 0);
    step(6'h00, 0, 1, 1, 0, 0, 0, 0);
    step(6'h00, 0, 6, 6, 0, 0, 0, 0);
    step(6'h00, 0, 7, 7, 0, 0, 0, 0);
    // LW with a fetch stall and three memory wait cycles; op changes after DECODE
    step(6'h23, 0, 0, 0, 1, 1, 0, 0);
    step(6'h23, 1, 0, 0, 1, 1, 0, 0);
    step(6'h23, 0, 1, 1, 1, 1, 0, 0);
    step(6'h00, 0, 2, 2, 1, 1, 0, 0);
    step(6'h00, 0, 3, 3, 1, 1, 0, 0);
    step(6'h00, 0, 3, 3, 1, 1, 0, 0);
    step(6'h00, 0, 3, 3, 1, 1, 0, 0);
    step(6'h00, 1, 3, 3, 1, 1, 0, 0);
    step(6'h00, 0, 4, 4, 1, 1, 0, 0);
    // SW
    step(6'h2B, 1, 0, 0, 2, 2, 0, 0);
    step(6'h2B, 1, 1, 1, 2, 2, 0, 0);
    step(6'h00, 1, 2, 2, 2, 2, 0, 0);
    step(6'h00, 0, 5, 5, 2, 2, 0, 0);
    step(6'h00, 1, 5, 5, 2, 2, 0, 0);
    // J
    step(6'h02, 1, 0, 0, 3, 3, 0, 0);
    step(6'h02, 0, 1, 1, 3, 3, 0, 0);
    step(6'h00, 0, 11, 11, 3, 3, 0, 0);
    // BEQ (B counter wraps to 0 here)
    step(6'h04, 1, 0, 0, 4, 0, 0, 0);
    step(6'h04, 0, 1, 1, 4, 0, 0, 0);
    step(6'h00, 0, 8, 8, 4, 0, 0, 0);
    // Illegal 111111: A traps, B pulses illegal and returns to FETCH
    step(6'h3F, 1, 0, 0, 5, 1, 0, 0);
    step(6'h3F, 0, 1, 1, 5, 1, 0, 1);
    step(6'h00, 0, 12, 0, 5, 1, 0, 0);
    step(6'h00, 0, 12, 0, 5, 1, 0, 0);
    async_reset_check();

    // BNE: A traps (disabled), B branches with branch_ne
    step(6'h05, 1, 0, 0, 0, 0, 0, 0);
    step(6'h05, 0, 1, 1, 0, 0, 0, 0);
    step(6'h00, 0, 12, 8, 0, 0, 1, 0);
    step(6'h00, 0, 12, 0, 0, 1, 0, 0);
    async_reset_check();

    // Five ADDIs: B counter reads 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      step(6'h08, 1, 0, 0, k, k % 4, 0, 0);
      step(6'h08, 0, 1, 1, k, k % 4, 0, 0);
      step(6'h00, 0, 9, 9, k, k % 4, 0, 0);
      step(6'h00, 0, 10, 10, k, k % 4, 0, 0);
    end
    step(6'h00, 0, 0, 0, 5, 1, 0, 0);

    // SW interrupted by reset while in MEMWR
    step(6'h2B, 1, 0, 0, 5, 1, 0, 0);
    step(6'h2B, 0, 1, 1, 5, 1, 0, 0);
    step(6'h00, 0, 2, 2, 5, 1, 0, 0);
    step(6'h00, 0, 5, 5, 5, 1, 0, 0);
    async_reset_check();
    step(6'h00, 0, 0, 0, 0, 0, 0, 0);

    if (sb_q.size() != 0) chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout step=%0d", stepn);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
